// File: rtl/disp_history_if.sv
// Bus between the CPU/button side and the display-history feeder.
// The master drives the write strobe and raw buttons; the slave drives the display outputs.
interface disp_history_if #(
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          btn_prev;
  logic          btn_live;
  logic [7:0]    dout;
  logic          dout_en;
  logic          browsing;
  logic [AW-1:0] index;
  logic [AW:0]   count;

  modport master (
    output wr_en, wr_data, btn_prev, btn_live,
    input  dout, dout_en, browsing, index, count
  );

  modport slave (
    input  wr_en, wr_data, btn_prev, btn_live,
    output dout, dout_en, browsing, index, count
  );
endinterface

// File: rtl/disp_history.sv
// Circular history of CPU-written values with debounced browse buttons.
// Presents a registered, quasi-static value to the seven-segment display stage.
module disp_history #(
  parameter int DEPTH     = 8,
  parameter int DB_CYCLES = 50000
) (
  input logic           clk,
  input logic           rst,
  disp_history_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [AW:0] L_ONE = (AW+1)'(1);
  localparam logic [AW:0] L_TWO = (AW+1)'(2);
  localparam logic [AW:0] L_DEP = (AW+1)'(DEPTH);
  localparam logic [AW:0] L_MAX = (AW+1)'(DEPTH-1);
  localparam logic [CW-1:0] L_DB = CW'(DB_CYCLES-1);

  typedef enum logic {LIVE, BROWSE} state_t;

  // bit 0 = prev button, bit 1 = live button
  logic [1:0]    w_btn;
  logic [1:0]    r_s1, r_s2, r_stab, r_pls;
  logic [CW-1:0] r_cnt [2];
  logic          w_p_prev, w_p_live;

  assign w_btn    = {bus.btn_live, bus.btn_prev};
  assign w_p_prev = r_pls[0];
  assign w_p_live = r_pls[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stab   <= '0;
      r_pls    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_s1 <= w_btn;
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        r_pls[i] <= 1'b0;
        if (r_s2[i] != r_stab[i]) begin
          if (r_cnt[i] == L_DB) begin
            r_stab[i] <= r_s2[i];
            r_pls[i]  <= r_s2[i];
            r_cnt[i]  <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp, w_wp_nx, w_raddr, r_index, w_idx_nx;
  logic [AW:0]   r_count, w_cnt_nx, w_idx;
  logic [7:0]    r_dout, w_dout_nx;
  logic          r_dout_en, r_browsing;
  state_t        r_state, w_state_nx;

  always_comb begin
    w_wp_nx    = r_wp;
    w_cnt_nx   = r_count;
    w_state_nx = r_state;
    w_idx      = {1'b0, r_index};
    if (bus.wr_en) begin
      w_wp_nx = r_wp + 1'b1;
      if (r_count != L_DEP) w_cnt_nx = r_count + L_ONE;
    end
    unique case (r_state)
      LIVE: begin
        w_idx = '0;
        if (!w_p_live && w_p_prev && w_cnt_nx >= L_TWO) begin
          w_state_nx = BROWSE;
          w_idx      = L_ONE;
        end
      end
      BROWSE: begin
        if (w_p_live) begin
          w_state_nx = LIVE;
          w_idx      = '0;
        end else begin
          if (bus.wr_en) w_idx = w_idx + L_ONE;
          // shown entry overwritten: fall back to the live value
          if (w_idx > L_MAX) begin
            w_state_nx = LIVE;
            w_idx      = '0;
          end else if (w_p_prev && (w_idx + L_ONE <= w_cnt_nx - L_ONE)) begin
            w_idx = w_idx + L_ONE;
          end
        end
      end
      default: begin
        w_state_nx = LIVE;
        w_idx      = '0;
      end
    endcase
    w_idx_nx = w_idx[AW-1:0];
    w_raddr  = w_wp_nx - 1'b1 - w_idx_nx;
    if (w_cnt_nx == '0)
      w_dout_nx = '0;
    else if (bus.wr_en && w_raddr == r_wp)
      w_dout_nx = bus.wr_data;
    else
      w_dout_nx = r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en) r_mem[r_wp] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_count    <= '0;
      r_index    <= '0;
      r_state    <= LIVE;
      r_dout     <= '0;
      r_dout_en  <= 1'b0;
      r_browsing <= 1'b0;
    end else begin
      r_wp       <= w_wp_nx;
      r_count    <= w_cnt_nx;
      r_index    <= w_idx_nx;
      r_state    <= w_state_nx;
      r_dout     <= w_dout_nx;
      r_dout_en  <= (w_cnt_nx != '0);
      r_browsing <= (w_state_nx == BROWSE);
    end
  end

  assign bus.dout     = r_dout;
  assign bus.dout_en  = r_dout_en;
  assign bus.browsing = r_browsing;
  assign bus.index    = r_index;
  assign bus.count    = r_count;
endmodule

// File: tb/tb_disp_history.sv
// Scoreboard bench for disp_history: stimulus queues expected outputs,
// a monitor pops and compares them at the scheduled cycle.
module tb_disp_history;
  localparam int DEPTH = 8;
  localparam int DB    = 4;
  localparam int HOLD  = DB + 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nid = 0;

  typedef struct {
    logic [7:0] d;
    logic       en;
    logic       br;
    logic [2:0] ix;
    logic [3:0] ct;
    int         due;
    int         id;
  } exp_t;

  exp_t q[$];

  disp_history_if #(.DEPTH(DEPTH)) bus ();

  disp_history #(.DEPTH(DEPTH), .DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_out(input logic [7:0] d, input logic en,
                            input logic br, input logic [2:0] ix,
                            input logic [3:0] ct);
    exp_t e;
    e.d = d; e.en = en; e.br = br; e.ix = ix; e.ct = ct;
    e.due = cyc;
    e.id = nid;
    nid++;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (bus.dout !== e.d || bus.dout_en !== e.en || bus.browsing !== e.br ||
          bus.index !== e.ix || bus.count !== e.ct) begin
        errors++;
        $display("FAIL chk%0d got dout=%h en=%b br=%b idx=%0d cnt=%0d want dout=%h en=%b br=%b idx=%0d cnt=%0d",
                 e.id, bus.dout, bus.dout_en, bus.browsing, bus.index, bus.count,
                 e.d, e.en, e.br, e.ix, e.ct);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [7:0] v);
    step();
    bus.wr_en   = 1'b1;
    bus.wr_data = v;
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic press(input logic p, input logic l);
    step();
    bus.btn_prev = p;
    bus.btn_live = l;
    repeat (HOLD) step();
    bus.btn_prev = 1'b0;
    bus.btn_live = 1'b0;
    repeat (HOLD) step();
  endtask

  task automatic do_rst();
    step();
    rst = 1'b1;
    #1;
    expect_out(8'h00, 1'b0, 1'b0, 3'd0, 4'd0);
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = 8'h00;
    bus.btn_prev = 1'b0;
    bus.btn_live = 1'b0;
    #1 rst = 1'b1;
    step();
    expect_out(8'h00, 1'b0, 1'b0, 3'd0, 4'd0);
    step();
    rst = 1'b0;

    wr(8'd5);
    expect_out(8'd5, 1'b1, 1'b0, 3'd0, 4'd1);

    do_rst();
    wr(8'd10);
    wr(8'd20);
    wr(8'd30);
    expect_out(8'd30, 1'b1, 1'b0, 3'd0, 4'd3);
    press(1'b1, 1'b0);
    expect_out(8'd20, 1'b1, 1'b1, 3'd1, 4'd3);
    press(1'b1, 1'b0);
    expect_out(8'd10, 1'b1, 1'b1, 3'd2, 4'd3);
    press(1'b1, 1'b0);
    expect_out(8'd10, 1'b1, 1'b1, 3'd2, 4'd3);

    press(1'b0, 1'b1);
    expect_out(8'd30, 1'b1, 1'b0, 3'd0, 4'd3);
    press(1'b1, 1'b0);
    expect_out(8'd20, 1'b1, 1'b1, 3'd1, 4'd3);
    wr(8'hF9);
    expect_out(8'd20, 1'b1, 1'b1, 3'd2, 4'd4);
    press(1'b0, 1'b1);
    expect_out(8'hF9, 1'b1, 1'b0, 3'd0, 4'd4);

    step();
    bus.btn_prev = 1'b1;
    step();
    step();
    bus.btn_prev = 1'b0;
    repeat (HOLD) step();
    expect_out(8'hF9, 1'b1, 1'b0, 3'd0, 4'd4);

    do_rst();
    for (int i = 1; i <= 9; i++) wr(8'(i));
    expect_out(8'd9, 1'b1, 1'b0, 3'd0, 4'd8);
    press(1'b1, 1'b0);
    expect_out(8'd8, 1'b1, 1'b1, 3'd1, 4'd8);
    for (int i = 0; i < 6; i++) press(1'b1, 1'b0);
    expect_out(8'd2, 1'b1, 1'b1, 3'd7, 4'd8);
    press(1'b1, 1'b0);
    expect_out(8'd2, 1'b1, 1'b1, 3'd7, 4'd8);
    wr(8'd100);
    expect_out(8'd100, 1'b1, 1'b0, 3'd0, 4'd8);

    press(1'b1, 1'b0);
    expect_out(8'd9, 1'b1, 1'b1, 3'd1, 4'd8);
    press(1'b1, 1'b1);
    expect_out(8'd100, 1'b1, 1'b0, 3'd0, 4'd8);

    press(1'b1, 1'b0);
    expect_out(8'd9, 1'b1, 1'b1, 3'd1, 4'd8);
    do_rst();
    press(1'b1, 1'b0);
    expect_out(8'h00, 1'b0, 1'b0, 3'd0, 4'd0);

    repeat (3) step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_history.md
# disp_history

Upstream feeder for the 4-digit seven-segment display stage. Captures signed 8-bit values written by the CPU into an 8-entry circular history. Two debounced push-buttons let the user browse older values or return to the live value. Drives the display's `din`/`en` pair with a registered, quasi-static value so the slower display clock can sample it safely.

## Interface
- `DEPTH`, 8: history entries; power of two, ≥2.
- `DB_CYCLES`, 50000: consecutive stable `clk` cycles needed to accept a button level change; ≥1.
- `clk  in  1`: system clock.
- `rst  in  1`: asynchronous, active-high reset.
- `wr_en  in  1`: CPU write strobe; one write per cycle when high.
- `wr_data  in  8`: signed value to record.
- `btn_prev  in  1`: raw, asynchronous button; step to the next-older entry.
- `btn_live  in  1`: raw, asynchronous button; return to the newest entry.
- `dout  out  8`: signed value shown; connects to the display's `din`.
- `dout_en  out  1`: level; connects to the display's `en`.
- `browsing  out  1`: high in state BROWSE; drives an LED.
- `index  out  log2(DEPTH)`: age of the shown entry; 0 = newest.
- `count  out  log2(DEPTH)+1`: number of valid entries, 0..DEPTH.

## Operation
- **Storage**
  - `mem[DEPTH]` holds 8-bit entries; write pointer `wp`.
  - On `wr_en`: `mem[wp] <= wr_data`; `wp <= wp+1` mod DEPTH; `count <= min(count+1, DEPTH)`.
  - Write wrap-around overwrites the oldest entry.
- **Read address**: `(wp_next - 1 - index_next)` mod DEPTH. When the addressed entry is being written in the same cycle, `wr_data` is bypassed.
- **Debounce** (one instance per button)
  - 2-flop synchronizer, then counter.
  - While the synchronized input ≠ the stable level, the counter increments; otherwise it clears.
  - At count == DB_CYCLES-1 the stable level flips and the counter clears.
  - A 0→1 transition of the stable level produces a one-cycle pulse (`p_prev` / `p_live`).
- **FSM**, states LIVE and BROWSE
  - **LIVE**: `index` = 0; `dout` follows the newest entry.
    - `p_prev` with `count_next ≥ 2` → BROWSE, `index` = 1.
    - `p_prev` with `count_next < 2` is ignored.
  - **BROWSE**: `dout` holds the selected entry.
    - Each write increments `index` so the same entry stays displayed.
    - `p_prev` increments `index` only if `index+1 ≤ count_next-1`; otherwise it is ignored (saturates at the oldest entry).
    - Write and `p_prev` in the same cycle: `index` advances by up to 2, each increment checked as above.
    - If a write makes `index` exceed DEPTH-1 (the shown entry is overwritten) → LIVE, `index` = 0.
    - `p_live` → LIVE, `index` = 0.
  - `p_live` and `p_prev` in the same cycle: `p_live` wins.
- **Outputs**
  - `dout` is registered from the read address each cycle.
  - `dout_en` = (`count_next` ≠ 0), registered.
  - `browsing`, `index` and `count` are registered.

## Timing
- Reset (async assert, synchronous-release use assumed external):
  - `dout` = 0, `dout_en` = 0, `browsing` = 0, `index` = 0, `count` = 0.
  - `wp` = 0; state = LIVE.
  - Debounce stable levels = 0; counters = 0; synchronizers = 0.
  - `mem` contents are not reset and are never visible while `count` = 0.
- Write latency: `wr_en` at edge N → `dout` = `wr_data` (in LIVE) and updated `count` after edge N+1... i.e. visible in cycle N+1.
- Button latency: raw level stable from cycle M → pulse at M+2+DB_CYCLES (±1) → `dout`/`index` update one cycle later.
- Glitches shorter than DB_CYCLES cycles produce no pulse.
- Held button: one pulse per press, none on release.
- Reset mid-browse: immediate return to the reset values; history is discarded (`count` = 0).
- `dout` changes at most once per `clk` and otherwise stays stable; the display's clock samples it as a quasi-static bus.

## Test plan
- **Reset, then write 5**: `wr_en` with 8'sd5 → next cycle `dout` = 5, `dout_en` = 1, `count` = 1, `browsing` = 0.
- **Browse**: write 10, 20, 30 (DB_CYCLES = 4), then press prev twice → `dout` 20 then 10, `index` 1 then 2. A third press → `dout` stays 10, `index` = 2.
- **Write while browsing**: showing 20 (`index` 1) and write -7 → `dout` stays 20, `index` = 2. Press live → `dout` = -7 (8'hF9), `browsing` = 0.
- **Overwrite exit**: write 9 values 1..9, press prev 7 times (`index` 7, `dout` = 2), write 100 → state LIVE, `dout` = 100, `count` = 8.
- **Debounce**: 2-cycle glitch on `btn_prev` → no change. Simultaneous prev+live pulses in BROWSE → LIVE, newest value shown.
- **Reset mid-browse**: assert `rst` in BROWSE → all outputs 0 immediately. A prev press afterwards is ignored (`count` = 0).
